// File: rtl/matmul_pkg.sv
// Shared types and sizing for the matmul engine: operand/result matrices,
// sequencer state encoding and counter widths.
package matmul_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int BUS_WIDTH  = 32;
  localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH;
  localparam int DIM_W      = $clog2(MAX_DIM);
  localparam int CNT_W      = $clog2(3 * MAX_DIM);
  localparam int ACC_W      = 2 * DATA_WIDTH + DIM_W;

  typedef logic [MAX_DIM-1:0][MAX_DIM-1:0][DATA_WIDTH-1:0] matA;
  typedef logic [MAX_DIM-1:0][MAX_DIM-1:0][DATA_WIDTH-1:0] matB;
  typedef logic [MAX_DIM-1:0][MAX_DIM-1:0][ACC_W-1:0]      matC;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    DONE
  } seqState_e;
endpackage

// File: rtl/matmul_skew_mux.sv
// Diagonal skew selector: picks the element for each grid edge lane at feed
// step t. COL_MAJOR=0 walks rows of A, COL_MAJOR=1 walks columns of B.
module matmul_skew_mux
  import matmul_pkg::*;
#(
  parameter bit COL_MAJOR = 1'b0
) (
  input  matA                                mat,
  input  logic [CNT_W-1:0]                   t,
  input  logic [DIM_W:0]                     laneLim,
  input  logic [DIM_W:0]                     kLim,
  input  logic                               en,
  output logic [MAX_DIM-1:0][DATA_WIDTH-1:0] lanes
);
  for (genvar i = 0; i < MAX_DIM; i++) begin : gLane
    logic [CNT_W-1:0] d;
    logic             hit;
    // d is only meaningful when t >= i; hit masks the wrapped case
    assign d   = t - CNT_W'(i);
    assign hit = en && ((DIM_W+1)'(i) < laneLim) && (t >= CNT_W'(i)) &&
                 (d < CNT_W'(kLim));
    if (COL_MAJOR) begin : gCol
      assign lanes[i] = hit ? mat[d[DIM_W-1:0]][i] : '0;
    end else begin : gRow
      assign lanes[i] = hit ? mat[i][d[DIM_W-1:0]] : '0;
    end
  end
endmodule

// File: rtl/matmul_seq_ctrl.sv
// Sequencer for the output-stationary PE grid: latches a job, clears the
// accumulators, streams skewed A/B edges, drains one cycle, then pulses done.
module matmul_seq_ctrl
  import matmul_pkg::*;
(
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          start_i,
  input  logic [DIM_W-1:0]              n_m1_i,
  input  logic [DIM_W-1:0]              k_m1_i,
  input  logic [DIM_W-1:0]              m_m1_i,
  input  matA                           mat_a_i,
  input  matB                           mat_b_i,
  output logic [MAX_DIM*DATA_WIDTH-1:0] a_west_o,
  output logic [MAX_DIM*DATA_WIDTH-1:0] b_north_o,
  output logic                          pe_clr_o,
  output logic                          pe_en_o,
  output logic                          busy_o,
  output logic                          done_o
);
  seqState_e        state, stateNxt;
  logic [CNT_W-1:0] t, tLast;
  logic [DIM_W:0]   nDim, kDim, mDim;
  matA              aQ;
  matB              bQ;
  logic             feeding;
  logic [MAX_DIM-1:0][DATA_WIDTH-1:0] aLanes, bLanes;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= stateNxt;
  end

  // Job context is captured only on the accepting edge; later input churn is ignored
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      t    <= '0;
      nDim <= '0;
      kDim <= '0;
      mDim <= '0;
      aQ   <= '0;
      bQ   <= '0;
    end else begin
      if (state == IDLE && start_i) begin
        nDim <= {1'b0, n_m1_i} + (DIM_W+1)'(1);
        kDim <= {1'b0, k_m1_i} + (DIM_W+1)'(1);
        mDim <= {1'b0, m_m1_i} + (DIM_W+1)'(1);
        aQ   <= mat_a_i;
        bQ   <= mat_b_i;
      end
      if (state == CLEAR)     t <= '0;
      else if (state == FEED) t <= t + CNT_W'(1);
    end
  end

  // Last feed step is T-1 = K+N+M-3
  assign tLast = CNT_W'(nDim) + CNT_W'(kDim) + CNT_W'(mDim) - CNT_W'(3);

  always_comb begin
    stateNxt = state;
    pe_clr_o = 1'b0;
    pe_en_o  = 1'b0;
    busy_o   = 1'b1;
    done_o   = 1'b0;
    feeding  = 1'b0;
    case (state)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i) stateNxt = CLEAR;
      end
      CLEAR: begin
        pe_clr_o = 1'b1;
        stateNxt = FEED;
      end
      FEED: begin
        pe_en_o = 1'b1;
        feeding = 1'b1;
        if (t == tLast) stateNxt = DRAIN;
      end
      DRAIN: begin
        pe_en_o  = 1'b1;
        stateNxt = DONE;
      end
      DONE: begin
        done_o   = 1'b1;
        stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

  matmul_skew_mux #(.COL_MAJOR(1'b0)) uSkewA (
    .mat(aQ), .t(t), .laneLim(nDim), .kLim(kDim), .en(feeding), .lanes(aLanes)
  );

  matmul_skew_mux #(.COL_MAJOR(1'b1)) uSkewB (
    .mat(bQ), .t(t), .laneLim(mDim), .kLim(kDim), .en(feeding), .lanes(bLanes)
  );

  assign a_west_o  = aLanes;
  assign b_north_o = bLanes;
endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Directed bench for matmul_seq_ctrl: reset, skewed lane contents, timing of
// clear/feed/drain/done, start masking while busy and back-to-back jobs.
module tb_matmul_seq_ctrl;
  import matmul_pkg::*;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic start_i = 1'b0;
  logic [DIM_W-1:0] n_m1_i = '0, k_m1_i = '0, m_m1_i = '0;
  matA mat_a_i = '0;
  matB mat_b_i = '0;
  logic [MAX_DIM*DATA_WIDTH-1:0] a_west_o, b_north_o;
  logic pe_clr_o, pe_en_o, busy_o, done_o;

  int nTot = 0;
  int nBad = 0;

  matmul_seq_ctrl dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i),
    .n_m1_i(n_m1_i), .k_m1_i(k_m1_i), .m_m1_i(m_m1_i),
    .mat_a_i(mat_a_i), .mat_b_i(mat_b_i),
    .a_west_o(a_west_o), .b_north_o(b_north_o),
    .pe_clr_o(pe_clr_o), .pe_en_o(pe_en_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTot++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_WIDTH-1:0] aLane(input int i);
    return a_west_o[i*DATA_WIDTH +: DATA_WIDTH];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] bLane(input int i);
    return b_north_o[i*DATA_WIDTH +: DATA_WIDTH];
  endfunction

  function automatic logic [31:0] ctl();
    return {28'd0, pe_clr_o, pe_en_o, busy_o, done_o};
  endfunction

  byte unsigned expA0[5] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd0};
  byte unsigned expA1[5] = '{8'd0, 8'd5, 8'd6, 8'd7, 8'd8};
  byte unsigned expB0[5] = '{8'd9, 8'd10, 8'd11, 8'd12, 8'd0};
  byte unsigned expA3[10] = '{8'h00, 8'h00, 8'h00, 8'h31, 8'h32, 8'h33, 8'h34, 8'h00, 8'h00, 8'h00};
  byte unsigned expB2[10] = '{8'h00, 8'h00, 8'h82, 8'h92, 8'ha2, 8'hb2, 8'h00, 8'h00, 8'h00, 8'h00};

  initial begin
    logic sawDone;

    // reset state
    #12;
    chk("rst_ctl", ctl(), 32'h0);
    chk("rst_a", a_west_o, 32'h0);
    chk("rst_b", b_north_o, 32'h0);
    rst_ni = 1'b1;
    tick();
    chk("idle_ctl", ctl(), 32'h0);

    // N=2 K=4 M=1, out-of-range elements filled with junk to prove masking
    mat_a_i = {MAX_DIM*MAX_DIM{8'hee}};
    mat_b_i = {MAX_DIM*MAX_DIM{8'hdd}};
    for (int k = 0; k < 4; k++) begin
      mat_a_i[0][k] = 8'(k + 1);
      mat_a_i[1][k] = 8'(k + 5);
      mat_b_i[k][0] = 8'(k + 9);
    end
    n_m1_i = 2'd1; k_m1_i = 2'd3; m_m1_i = 2'd0;
    start_i = 1'b1;
    tick();  // E0
    start_i = 1'b0;
    mat_a_i = {MAX_DIM*MAX_DIM{8'h55}};
    mat_b_i = {MAX_DIM*MAX_DIM{8'h66}};
    n_m1_i = 2'd3; k_m1_i = 2'd3; m_m1_i = 2'd3;
    chk("def_clear_ctl", ctl(), 32'b1010);
    chk("def_clear_a", a_west_o, 32'h0);
    for (int t = 0; t < 5; t++) begin
      tick();
      chk($sformatf("def_ctl_t%0d", t), ctl(), 32'b0110);
      chk($sformatf("def_a0_t%0d", t), aLane(0), expA0[t]);
      chk($sformatf("def_a1_t%0d", t), aLane(1), expA1[t]);
      chk($sformatf("def_a23_t%0d", t), a_west_o[31:16], 32'h0);
      chk($sformatf("def_b0_t%0d", t), bLane(0), expB0[t]);
      chk($sformatf("def_b123_t%0d", t), b_north_o[31:8], 32'h0);
    end
    tick();  // E6 drain
    chk("def_drain_ctl", ctl(), 32'b0110);
    chk("def_drain_a", a_west_o, 32'h0);
    chk("def_drain_b", b_north_o, 32'h0);
    // start during DRAIN with different dims must be ignored
    start_i = 1'b1;
    n_m1_i = 2'd0; k_m1_i = 2'd0; m_m1_i = 2'd0;
    tick();  // E7
    start_i = 1'b0;
    chk("def_done_ctl", ctl(), 32'b0011);
    tick();
    chk("def_idle_ctl", ctl(), 32'h0);
    tick();
    chk("ign_no_job", ctl(), 32'h0);

    // N=K=M=1
    mat_a_i = {MAX_DIM*MAX_DIM{8'hff}};
    mat_b_i = {MAX_DIM*MAX_DIM{8'hff}};
    mat_a_i[0][0] = 8'd3;
    mat_b_i[0][0] = 8'd7;
    n_m1_i = 2'd0; k_m1_i = 2'd0; m_m1_i = 2'd0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("min_clear_ctl", ctl(), 32'b1010);
    tick();
    chk("min_feed_ctl", ctl(), 32'b0110);
    chk("min_feed_a", a_west_o, 32'h3);
    chk("min_feed_b", b_north_o, 32'h7);
    tick();
    chk("min_drain_ctl", ctl(), 32'b0110);
    chk("min_drain_a", a_west_o, 32'h0);
    tick();
    chk("min_done_ctl", ctl(), 32'b0011);
    tick();
    chk("min_idle_ctl", ctl(), 32'h0);

    // all-max dims
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        mat_a_i[r][c] = 8'(16*r + c + 1);
        mat_b_i[r][c] = 8'(8'h80 + 16*r + c);
      end
    n_m1_i = 2'd3; k_m1_i = 2'd3; m_m1_i = 2'd3;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("max_clear_ctl", ctl(), 32'b1010);
    for (int t = 0; t < 10; t++) begin
      tick();
      chk($sformatf("max_ctl_t%0d", t), ctl(), 32'b0110);
      chk($sformatf("max_a3_t%0d", t), aLane(3), expA3[t]);
      chk($sformatf("max_b2_t%0d", t), bLane(2), expB2[t]);
    end
    chk("max_a0_t9", aLane(0), 32'h0);
    tick();  // E11
    chk("max_drain_ctl", ctl(), 32'b0110);
    tick();  // E12
    chk("max_done_ctl", ctl(), 32'b0011);
    tick();
    chk("max_idle_ctl", ctl(), 32'h0);

    // back-to-back with start held high
    mat_a_i = '0;
    mat_b_i = '0;
    mat_a_i[0][0] = 8'd5;
    mat_b_i[0][0] = 8'd6;
    n_m1_i = 2'd0; k_m1_i = 2'd0; m_m1_i = 2'd0;
    start_i = 1'b1;
    tick();
    mat_a_i[0][0] = 8'd9;
    mat_b_i[0][0] = 8'd2;
    chk("b2b_clear1", ctl(), 32'b1010);
    tick();
    chk("b2b_feed1_a", a_west_o, 32'h5);
    chk("b2b_feed1_b", b_north_o, 32'h6);
    tick();
    chk("b2b_drain1", ctl(), 32'b0110);
    tick();
    chk("b2b_done1", ctl(), 32'b0011);
    tick();
    chk("b2b_idle", ctl(), 32'h0);
    tick();
    chk("b2b_clear2", ctl(), 32'b1010);
    start_i = 1'b0;
    mat_a_i[0][0] = 8'd1;
    mat_b_i[0][0] = 8'd1;
    tick();
    chk("b2b_feed2_a", a_west_o, 32'h9);
    chk("b2b_feed2_b", b_north_o, 32'h2);
    tick();
    tick();
    chk("b2b_done2", ctl(), 32'b0011);
    tick();
    chk("b2b_idle2", ctl(), 32'h0);

    // reset mid-FEED at t=2
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        mat_a_i[r][c] = 8'(16*r + c + 1);
        mat_b_i[r][c] = 8'(8'h80 + 16*r + c);
      end
    n_m1_i = 2'd3; k_m1_i = 2'd3; m_m1_i = 2'd3;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    tick();
    chk("rmid_pre_a0", aLane(2), 32'h21);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("rmid_ctl", ctl(), 32'h0);
    chk("rmid_a", a_west_o, 32'h0);
    chk("rmid_b", b_north_o, 32'h0);
    tick();
    rst_ni = 1'b1;
    sawDone = 1'b0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (done_o || busy_o) sawDone = 1'b1;
    end
    chk("rmid_no_done", {31'd0, sawDone}, 32'h0);
    chk("rmid_idle", ctl(), 32'h0);

    $display("test done: total=%0d bad=%0d", nTot, nBad);
    $finish;
  end
endmodule
